// File: rtl/carga_operandos.sv
// Operand-load / result-capture stage around a WIDTH-bit A >= B comparator.
// Latency: operand captured at the edge where the strobe pulse is seen (+2 edges with CARGA_SYNC_EN); result one edge after B.
// Backpressure: none; pulses arriving in COMPARA are dropped, borrar overrides everything.
//
// Optional feature: define CARGA_SYNC_EN to put a two-flop synchronizer on cargar.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   dato         shared operand data (switches)
//   cargar       load strobe level; each rising edge loads one operand
//   borrar       synchronous clear, active-high, highest priority
//   D_in         comparator result for the current A/B
//   A, B         registered operands driving the comparator
//   resultado    registered comparison result, valid while listo=1
//   listo        resultado belongs to the current A/B pair
//   fase         FSM state encoding for LEDs/debug

module carga_operandos #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] dato,
   input  logic             cargar,
   input  logic             borrar,
   input  logic             D_in,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             resultado,
   output logic             listo,
   output logic [1:0]       fase
);

   typedef enum logic [1:0] {
      ESPERA_A = 2'b00,
      ESPERA_B = 2'b01,
      COMPARA  = 2'b10,
      MUESTRA  = 2'b11
   } estado_t;

   estado_t          estado, estado_nxt;
   logic [WIDTH-1:0] a_nxt, b_nxt;
   logic             resultado_nxt, listo_nxt;
   logic             estrobo;
   logic             cargar_q;
   logic             pulso;

`ifdef CARGA_SYNC_EN
   logic       sync1, sync2;
   logic [1:0] lleno;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         lleno <= 2'b00;
      end else begin
         sync1 <= cargar;
         sync2 <= sync1;
         lleno <= {lleno[0], 1'b1};
      end
   end

   assign estrobo = sync2;

   // The synchronizer comes out of reset holding 0, which the edge detector
   // would otherwise take as "seen low" and then fire on a button held
   // through reset. Keep cargar_q parked at 1 until the synchronizer has
   // been refilled with real samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cargar_q <= 1'b1;
      else        cargar_q <= lleno[1] ? estrobo : 1'b1;
   end
`else
   assign estrobo = cargar;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cargar_q <= 1'b1;
      else        cargar_q <= estrobo;
   end
`endif

   // Resetting cargar_q to 1 means a strobe held high across reset must be
   // seen low before it can load anything.
   assign pulso = estrobo & ~cargar_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= ESPERA_A;
         A         <= '0;
         B         <= '0;
         resultado <= 1'b0;
         listo     <= 1'b0;
      end else begin
         estado    <= estado_nxt;
         A         <= a_nxt;
         B         <= b_nxt;
         resultado <= resultado_nxt;
         listo     <= listo_nxt;
      end
   end

   always_comb begin
      estado_nxt    = estado;
      a_nxt         = A;
      b_nxt         = B;
      resultado_nxt = resultado;
      listo_nxt     = listo;
      if (borrar) begin
         // Clear wins over a simultaneous pulse, which is simply lost.
         estado_nxt    = ESPERA_A;
         a_nxt         = '0;
         b_nxt         = '0;
         resultado_nxt = 1'b0;
         listo_nxt     = 1'b0;
      end else begin
         case (estado)
            ESPERA_A: begin
               if (pulso) begin
                  a_nxt      = dato;
                  estado_nxt = ESPERA_B;
               end
            end
            ESPERA_B: begin
               if (pulso) begin
                  b_nxt      = dato;
                  estado_nxt = COMPARA;
               end
            end
            COMPARA: begin
               // B settled at the previous edge, so D_in is now stable.
               resultado_nxt = D_in;
               listo_nxt     = 1'b1;
               estado_nxt    = MUESTRA;
            end
            MUESTRA: begin
               // The press that starts a new pair also loads its A.
               if (pulso) begin
                  a_nxt      = dato;
                  listo_nxt  = 1'b0;
                  estado_nxt = ESPERA_B;
               end
            end
            default: estado_nxt = ESPERA_A;
         endcase
      end
   end

   assign fase = estado;

endmodule
